// File: rtl/uart_tx_buffer_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_buffer_fifo
//
// Staging buffer between the register slave and the UART transmit engine.
// Register writes are pushed into a synchronous FIFO. The TX engine drains
// the FIFO over a valid/ready handshake, and the head word is presented
// first-word-fall-through.
//
// The buffer also provides:
//   - a sticky overflow flag,
//   - a soft flush,
//   - a programmable almost-full threshold,
//   - a packed status word (tfi) for software polling.
//
// Parameters
//   DATA_W        FIFO word width in bits (8, 16 or 32)
//   DEPTH         FIFO depth in words (power of two, 4..4096)
//   PROG_FULL_TH  level at or above which tx_prog_full asserts (1..DEPTH)
//   AW            pointer width, derived from DEPTH
//
// Ports
//   clk_125             system clock, rising edge
//   rst_125             asynchronous active-high reset
//   slv_reg_wren        single-cycle write strobe for the TX data register
//   peripheral_data_in  write data, sampled with slv_reg_wren
//   flush               soft flush, empties the FIFO on the next edge
//   ovf_clr             clears the sticky overflow flag
//   tx_data             head-of-FIFO word (don't-care while empty)
//   tx_valid            tx_data is valid (== !tx_empty)
//   tx_ready            TX engine accepts tx_data this cycle
//   tx_level            current word count, 0..DEPTH
//   tx_empty            level == 0
//   tx_prog_full        level >= PROG_FULL_TH
//   tfi                 {prog_full, ovf, empty, 13'b0, free_bytes[15:0]}
// -----------------------------------------------------------------------------
module uart_tx_buffer_fifo #(
  parameter  int DATA_W       = 32,
  parameter  int DEPTH        = 256,
  parameter  int PROG_FULL_TH = 253,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic              clk_125,
  input  logic              rst_125,
  input  logic              slv_reg_wren,
  input  logic [DATA_W-1:0] peripheral_data_in,
  input  logic              flush,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [AW:0]       tx_level,
  output logic              tx_empty,
  output logic              tx_prog_full,
  output logic [31:0]       tfi
);

  localparam logic [AW:0]   DEPTH_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   TH_LVL    = (AW+1)'(PROG_FULL_TH);
  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [31:0]   WORD_BYTES = 32'(DATA_W / 8);

  // Storage and state
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       level_q, level_d;
  logic              ovf_q, ovf_d;

  // Handshake decode
  logic              full_s;
  logic              pop_s;
  logic              push_s;
  logic              ovf_set_s;
  logic [15:0]       free_bytes_s;

  // Transfer decode.
  // Flush wins over everything, so it masks both pop and push. A write that
  // arrives while full is still accepted if a pop frees a slot in the same
  // cycle. Only a write that is genuinely dropped raises the overflow.
  always_comb begin
    full_s    = (level_q == DEPTH_LVL);
    pop_s     = tx_valid & tx_ready & ~flush;
    push_s    = slv_reg_wren & (~full_s | pop_s) & ~flush;
    ovf_set_s = slv_reg_wren & full_s & ~pop_s & ~flush;
  end

  // Next-state computation for the pointers, level and overflow flag
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end

      if (pop_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end

      // The level is kept separately from the pointers so that full and
      // empty never alias once the pointers wrap.
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end

    // A coincident overflowing write beats the clear, so the event is not lost.
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_125 or posedge rst_125) begin
    if (rst_125) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array.
  // It needs no reset because reads are only meaningful while the level is
  // non-zero.
  always_ff @(posedge clk_125) begin
    if (push_s) begin
      mem_q[wptr_q] <= peripheral_data_in;
    end
  end

  // The asynchronous read of the registered array gives first-word-fall-through.
  // A word written at an edge is visible in the following cycle.
  assign tx_data      = mem_q[rptr_q];
  assign tx_valid     = (level_q != '0);
  assign tx_empty     = (level_q == '0);
  assign tx_prog_full = (level_q >= TH_LVL);
  assign tx_level     = level_q;

  // Free space in bytes, truncated to the 16-bit status field
  assign free_bytes_s = 16'(32'(DEPTH_LVL - level_q) * WORD_BYTES);

  assign tfi = {tx_prog_full, ovf_q, tx_empty, 13'd0, free_bytes_s};

endmodule
